// File: rtl/cla_pkg.sv
// Shared types and default sizing for the multi-word CLA sequencer.
package cla_pkg;

  localparam int NBITS  = 16;
  localparam int NWORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiword_cla_sequencer_slice.sv
// Combinational carry-lookahead adder used as the one-word slice of the sequencer.
module CarryLookAheadAdderAlwaysComb #(
  parameter int Nbits = 16
) (
  input  logic [Nbits-1:0] a_in,
  input  logic [Nbits-1:0] b_in,
  input  logic             Cin,
  output logic [Nbits-1:0] sum,
  output logic             Cout
);

  logic [Nbits-1:0] gen;
  logic [Nbits-1:0] prop;
  logic [Nbits:0]   carry;

  // Each carry is expanded from generate/propagate terms of the bits below it.
  always_comb begin
    gen      = a_in & b_in;
    prop     = a_in ^ b_in;
    carry    = '0;
    carry[0] = Cin;
    for (int i = 0; i < Nbits; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
    sum  = prop ^ carry[Nbits-1:0];
    Cout = carry[Nbits];
  end

endmodule

// File: rtl/multiword_cla_sequencer.sv
// Wide adder that pushes one Nbits word per cycle through a single CLA slice,
// chaining the carry between words in a register.
module multiword_cla_sequencer
  import cla_pkg::*;
#(
  parameter int Nbits  = NBITS,
  parameter int Nwords = NWORDS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [Nbits*Nwords-1:0]   a_in,
  input  logic [Nbits*Nwords-1:0]   b_in,
  input  logic                      Cin,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic [Nbits*Nwords-1:0]   sum,
  output logic                      Cout
);

  localparam int W     = Nbits * Nwords;
  localparam int IDX_W = $clog2(Nwords);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Nwords - 1);

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             carry;
  logic [Nbits-1:0] slice_sum;
  logic             slice_cout;

  CarryLookAheadAdderAlwaysComb #(
    .Nbits(Nbits)
  ) u_slice (
    .a_in (a_reg[idx*Nbits +: Nbits]),
    .b_in (b_reg[idx*Nbits +: Nbits]),
    .Cin  (carry),
    .sum  (slice_sum),
    .Cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) next_state = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (idx == LAST_IDX) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Upper words of sum are deliberately left alone on start; they are overwritten
  // word by word, and only the DONE cycle onward guarantees a consistent result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      sum   <= '0;
      Cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a_in;
            b_reg <= b_in;
            carry <= Cin;
            idx   <= '0;
          end
        end
        BUSY: begin
          sum[idx*Nbits +: Nbits] <= slice_sum;
          carry                   <= slice_cout;
          if (idx == LAST_IDX) begin
            Cout <= slice_cout;
            idx  <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_cla_sequencer.sv
// Self-checking bench: directed cases plus random additions against a 65-bit arithmetic model.
module tb_multiword_cla_sequencer;

  localparam int NB = 16;
  localparam int NW = 4;
  localparam int W  = NB * NW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         Cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         Cout;

  int compared   = 0;
  int mismatched = 0;

  multiword_cla_sequencer #(.Nbits(NB), .Nwords(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .Cin   (Cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  task automatic checkOutput(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one operation, waits (bounded) for done, returns latency in edges after acceptance.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                               input bit check_ready, output int latency);
    a_in    = a;
    b_in    = b;
    Cin     = c;
    start   = 1'b1;
    latency = -1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    Cin   = ~c;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (check_ready && n <= 4) checkOutput("ready_low_busy", {64'd0, ready}, 65'd0);
      if (done) begin
        latency = n;
        break;
      end
    end
    if (latency < 0) checkOutput("done_timeout", 65'd0, 65'd1);
    @(posedge clk);
    #1;
  endtask

  int           lat;
  logic [W-1:0] ops_a [18];
  logic [W-1:0] ops_b [18];
  logic         ops_c [18];
  logic [W-1:0] ra, rb;
  logic         rc;
  int           done_count;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    Cin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_result", {Cout, sum}, 65'd0);
    checkOutput("reset_ready", {64'd0, ready}, 65'd1);
    checkOutput("reset_busy", {64'd0, busy}, 65'd0);
    checkOutput("reset_done", {64'd0, done}, 65'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic add with full carry ripple through every word
    applyStimulus(64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, lat);
    checkOutput("basic_latency", 65'(lat), 65'd4);
    checkOutput("basic_result", {Cout, sum}, {1'b1, 64'h0});
    checkOutput("basic_ready_after", {64'd0, ready}, 65'd1);

    applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, lat);
    checkOutput("cin_result", {Cout, sum}, {1'b0, 64'h2222_2222_2222_2212});

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, lat);
    checkOutput("max_result", {Cout, sum}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});

    // Start held high with operands changing every cycle: accepts at edges 0, 6, 12
    for (int k = 0; k < 18; k++) begin
      ops_a[k] = {$urandom, $urandom};
      ops_b[k] = {$urandom, $urandom};
      ops_c[k] = 1'($urandom);
    end
    done_count = 0;
    start = 1'b1;
    for (int k = 0; k < 18; k++) begin
      a_in = ops_a[k];
      b_in = ops_b[k];
      Cin  = ops_c[k];
      @(posedge clk);
      #1;
      checkOutput("held_done_timing", {64'd0, done}, {64'd0, (k % 6 == 4)});
      if (done) begin
        done_count++;
        checkOutput("held_result", {Cout, sum},
                    ref_add(ops_a[k-4], ops_b[k-4], ops_c[k-4]));
      end
    end
    start = 1'b0;
    checkOutput("held_done_count", 65'(done_count), 65'd3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // Reset after two BUSY edges aborts without a done pulse
    a_in  = 64'hDEAD_BEEF_0123_4567;
    b_in  = 64'h1111_2222_3333_4444;
    Cin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_result", {Cout, sum}, 65'd0);
    checkOutput("abort_busy", {64'd0, busy}, 65'd0);
    checkOutput("abort_ready", {64'd0, ready}, 65'd1);
    checkOutput("abort_done", {64'd0, done}, 65'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_done", {64'd0, done}, 65'd0);
    end
    applyStimulus(64'hDEAD_BEEF_0123_4567, 64'h1111_2222_3333_4444, 1'b1, 1'b0, lat);
    checkOutput("after_abort_result", {Cout, sum},
                ref_add(64'hDEAD_BEEF_0123_4567, 64'h1111_2222_3333_4444, 1'b1));

    // Random operands, every fourth case with a word-wide run of ones to stress carries
    for (int t = 0; t < 1000; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      if (t % 4 == 0) rb = ~ra ^ W'($urandom_range(0, 3));
      applyStimulus(ra, rb, rc, 1'b0, lat);
      checkOutput("rand_latency", 65'(lat), 65'd4);
      checkOutput("rand_result", {Cout, sum}, ref_add(ra, rb, rc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
